// File: rtl/ocm_pkg.sv
// ocm_pkg: shared widths, FSM state type and the nibble-merge helper for the
// 4-bit-pixel on-chip-memory writer.
// Optional build macro: OCM_SKIP_TRANSPARENT_EN (pixel value 0 is transparent).
package ocm_pkg;

  localparam int PIX_W        = 4;
  localparam int WORD_W       = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int PADDR_W      = 20;
  localparam int WADDR_W      = 18;
  localparam int NIB_W        = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // accumulation buffer empty
    FILL  = 2'd1,  // buffer holds at least one seen nibble
    WRITE = 2'd2   // wr_req high, waiting for wr_ack
  } state_t;

  // Accumulated word: packed data, write enables, and which nibble indices
  // have been offered at all. seen differs from mask only when transparent
  // pixels are skipped.
  typedef struct packed {
    logic [WORD_W-1:0]       data;
    logic [PIX_PER_WORD-1:0] mask;
    logic [PIX_PER_WORD-1:0] seen;
  } acc_t;

  // Apply one pixel to an accumulated word. Later pixels to the same nibble
  // overwrite earlier ones.
  function automatic acc_t nib_apply(input acc_t                 acc,
                                     input logic [NIB_W-1:0]   idx,
                                     input logic [PIX_W-1:0]   pix);
    acc_t res;
    res           = acc;
    res.seen[idx] = 1'b1;
`ifdef OCM_SKIP_TRANSPARENT_EN
    if (pix == '0) begin
      // Transparent: keep whatever is in the nibble, but do not write it.
      res.mask[idx] = 1'b0;
    end else begin
      res.mask[idx]                           = 1'b1;
      res.data[int'(idx) * PIX_W +: PIX_W]    = pix;
    end
`else
    res.mask[idx]                        = 1'b1;
    res.data[int'(idx) * PIX_W +: PIX_W] = pix;
`endif
    return res;
  endfunction

endpackage

// File: rtl/ocm_word_buffer.sv
// ocm_word_buffer: the accumulation register of the pixel writer. Supports
// load (start a new word with one pixel), merge (add a pixel to the current
// word) and clear, and exposes both the current word and a preview of the
// word with the incoming pixel merged so the FSM can emit in the same cycle.
// Optional build macro: OCM_SKIP_TRANSPARENT_EN (handled inside nib_apply).
module ocm_word_buffer
  import ocm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    merge,
  input  logic                    clear,
  input  logic [WADDR_W-1:0]      in_word,
  input  logic [NIB_W-1:0]        in_nib,
  input  logic [PIX_W-1:0]        in_pix,
  output logic [WADDR_W-1:0]      word_addr,
  output logic [WORD_W-1:0]       cur_data,
  output logic [PIX_PER_WORD-1:0] cur_mask,
  output logic [WORD_W-1:0]       mrg_data,
  output logic [PIX_PER_WORD-1:0] mrg_mask,
  output logic                    mrg_full,
  output logic                    mrg_mask_zero,
  output logic                    cur_mask_zero,
  output logic                    empty
);

  acc_t               acc_q;
  acc_t               acc_mrg;
  acc_t               acc_ld;
  logic [WADDR_W-1:0] word_q;

  // Candidate next values: current word with the pixel merged, and a fresh
  // word holding only the pixel.
  always_comb begin
    acc_mrg = nib_apply(acc_q, in_nib, in_pix);
    acc_ld  = nib_apply(acc_t'('0), in_nib, in_pix);
  end

  // Accumulation register; load has priority because a word change both
  // retires the old word and starts the new one.
  // NOTE: the buffer is a handful of flops rather than a RAM, so it is reset
  // along with everything else; a real memory array would not be.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q  <= '0;
      word_q <= '0;
    end else if (load) begin
      acc_q  <= acc_ld;
      word_q <= in_word;
    end else if (clear) begin
      acc_q  <= '0;
    end else if (merge) begin
      acc_q  <= acc_mrg;
    end
  end

  assign word_addr     = word_q;
  assign cur_data      = acc_q.data;
  assign cur_mask      = acc_q.mask;
  assign mrg_data      = acc_mrg.data;
  assign mrg_mask      = acc_mrg.mask;
  assign mrg_full      = &acc_mrg.seen;
  assign mrg_mask_zero = ~|acc_mrg.mask;
  assign cur_mask_zero = ~|acc_q.mask;
  assign empty         = ~|acc_q.seen;

endmodule

// File: rtl/ocm_pixel_writer.sv
// ocm_pixel_writer: packs a stream of 4-bit pixels into 16-bit words and
// issues one masked word write per packed word towards the graphics memory.
// Holds the control FSM and the registered write-port outputs; the
// accumulation register lives in ocm_word_buffer.
// Optional build macro: OCM_SKIP_TRANSPARENT_EN -- pixel value 0 is accepted
// but not written, and words whose mask ends up empty are dropped.
module ocm_pixel_writer
  import ocm_pkg::*;
#(
  parameter int MAX_WORD = 187508
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [19:0] pix_addr,
  input  logic [3:0]  pix_data,
  input  logic        flush,
  output logic        idle,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [17:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [3:0]  wr_mask
);

  state_t state_q;
  state_t state_d;

  logic [WADDR_W-1:0]      in_word;
  logic [NIB_W-1:0]        in_nib;
  logic                    accept;
  logic                    in_range;
  logic                    take;
  logic                    same_word;

  logic                    buf_load;
  logic                    buf_merge;
  logic                    buf_clear;
  logic [WADDR_W-1:0]      buf_word;
  logic [WORD_W-1:0]       cur_data;
  logic [PIX_PER_WORD-1:0] cur_mask;
  logic [WORD_W-1:0]       mrg_data;
  logic [PIX_PER_WORD-1:0] mrg_mask;
  logic                    mrg_full;
  logic                    mrg_mask_zero;
  logic                    cur_mask_zero;
  logic                    buf_empty;

  logic                    emit;
  logic                    emit_mrg;

  assign in_word   = pix_addr[PADDR_W-1:NIB_W];
  assign in_nib    = pix_addr[NIB_W-1:0];
  assign pix_ready = (state_q != WRITE);
  assign accept    = pix_valid && pix_ready;
  assign in_range  = (in_word <= WADDR_W'(MAX_WORD));
  // Out-of-range pixels are consumed but never touch the buffer.
  assign take      = accept && in_range;
  assign same_word = (in_word == buf_word);

  assign idle      = (state_q == IDLE);
  assign wr_req    = (state_q == WRITE);

  ocm_word_buffer u_word_buffer (
    .clk           (clk),
    .reset_n       (reset_n),
    .load          (buf_load),
    .merge         (buf_merge),
    .clear         (buf_clear),
    .in_word       (in_word),
    .in_nib        (in_nib),
    .in_pix        (pix_data),
    .word_addr     (buf_word),
    .cur_data      (cur_data),
    .cur_mask      (cur_mask),
    .mrg_data      (mrg_data),
    .mrg_mask      (mrg_mask),
    .mrg_full      (mrg_full),
    .mrg_mask_zero (mrg_mask_zero),
    .cur_mask_zero (cur_mask_zero),
    .empty         (buf_empty)
  );

  // State register.
  // NOTE: clocked processes use non-blocking assignments so every flop samples
  // the pre-edge values; blocking ones would make results depend on order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and buffer/emit control.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    buf_load  = 1'b0;
    buf_merge = 1'b0;
    buf_clear = 1'b0;
    emit      = 1'b0;
    emit_mrg  = 1'b0;

    case (state_q)
      IDLE: begin
        // Flush alone has nothing to emit here.
        if (take) begin
          buf_load = 1'b1;
          state_d  = FILL;
        end
      end

      FILL: begin
        if (take && same_word) begin
          if (mrg_full || flush) begin
            // Merge and retire in one step: emit the merged preview.
            buf_clear = 1'b1;
            if (mrg_mask_zero) begin
              state_d = IDLE;
            end else begin
              emit     = 1'b1;
              emit_mrg = 1'b1;
              state_d  = WRITE;
            end
          end else begin
            buf_merge = 1'b1;
          end
        end else if (take) begin
          // Word change: retire the old word, start the new one. Any flush
          // this cycle is ignored; the caller keeps it high until idle.
          buf_load = 1'b1;
          if (!cur_mask_zero) begin
            emit    = 1'b1;
            state_d = WRITE;
          end
        end else if (flush) begin
          buf_clear = 1'b1;
          if (cur_mask_zero) begin
            state_d = IDLE;
          end else begin
            emit    = 1'b1;
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        // The buffer may already hold the pixel that caused a word change.
        if (wr_ack) begin
          state_d = buf_empty ? IDLE : FILL;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-port output registers; loaded only on emit, so they hold steady for
  // the whole WRITE phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr <= '0;
      wr_data <= '0;
      wr_mask <= '0;
    end else if (emit) begin
      wr_addr <= buf_word;
      wr_data <= emit_mrg ? mrg_data : cur_data;
      wr_mask <= emit_mrg ? mrg_mask : cur_mask;
    end
  end

endmodule

// File: tb/tb_ocm_pixel_writer.sv
// tb_ocm_pixel_writer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model of the
// pixel packing rules.
// Optional build macro: OCM_SKIP_TRANSPARENT_EN (model and one scenario follow it).
module tb_ocm_pixel_writer;

  localparam int MAX_WORD = 187508;
`ifdef OCM_SKIP_TRANSPARENT_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [19:0] pix_addr = '0;
  logic [3:0]  pix_data = '0;
  logic        flush = 1'b0;
  logic        idle;
  logic        wr_req;
  logic        wr_ack = 1'b1;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;

  always #5 clk = ~clk;

  ocm_pixel_writer #(.MAX_WORD(MAX_WORD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_addr  (pix_addr),
    .pix_data  (pix_data),
    .flush     (flush),
    .idle      (idle),
    .wr_req    (wr_req),
    .wr_ack    (wr_ack),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pending word (m_have) with its four nibble values, which ones are to be
  // written and which indices were offered; at most one write in flight.
  logic        m_busy;
  logic        m_have;
  logic [17:0] m_word;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_set;
  logic [3:0]  m_seen;
  logic [17:0] m_oaddr;
  logic [15:0] m_odata;
  logic [3:0]  m_omask;

  // Completed writes as seen on the bus, for the literal checks.
  logic [17:0] lg_addr[$];
  logic [15:0] lg_data[$];
  logic [3:0]  lg_mask[$];

  task automatic m_start(input logic [17:0] w);
    m_word = w;
    for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    m_set  = 4'h0;
    m_seen = 4'h0;
    m_have = 1'b1;
  endtask

  task automatic m_put(input logic [1:0] n, input logic [3:0] d);
    m_seen[n] = 1'b1;
    if (SKIP && d == 4'h0) begin
      m_set[n] = 1'b0;
    end else begin
      m_set[n] = 1'b1;
      m_nib[n] = d;
    end
  endtask

  // Retire the pending word; a word with nothing to write is simply dropped.
  task automatic m_emit();
    if (m_set != 4'h0) begin
      m_oaddr = m_word;
      m_odata = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      m_omask = m_set;
      m_busy  = 1'b1;
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_have  = 1'b0;
      m_word  = '0;
      m_set   = '0;
      m_seen  = '0;
      m_oaddr = '0;
      m_odata = '0;
      m_omask = '0;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    end else if (m_busy) begin
      if (wr_ack) m_busy = 1'b0;
    end else begin
      logic        inr;
      logic        had;
      logic [17:0] w;
      w   = pix_addr[19:2];
      inr = (int'(w) <= MAX_WORD);
      had = m_have;
      if (pix_valid && inr && (!m_have || w == m_word)) begin
        if (!m_have) m_start(w);
        m_put(pix_addr[1:0], pix_data);
        if (m_seen == 4'hF || (flush && had)) begin
          m_emit();
          m_have = 1'b0;
        end
      end else if (pix_valid && inr) begin
        m_emit();
        m_start(w);
        m_put(pix_addr[1:0], pix_data);
      end else if (flush && m_have) begin
        m_emit();
        m_have = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("pix_ready", pix_ready, !m_busy);
      check("idle", idle, !m_busy && !m_have);
      check("wr_req", wr_req, m_busy);
      if (m_busy) begin
        check("wr_addr", wr_addr, m_oaddr);
        check("wr_data", wr_data, m_odata);
        check("wr_mask", wr_mask, m_omask);
      end
      if (wr_req && wr_ack) begin
        lg_addr.push_back(wr_addr);
        lg_data.push_back(wr_data);
        lg_mask.push_back(wr_mask);
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] a, input logic [3:0] d);
    int k;
    k = 0;
    while (!pix_ready && k < 100) begin
      cyc();
      k++;
    end
    if (!pix_ready) check("send_ready_timeout", 32'd0, 32'd1);
    pix_valid = 1'b1;
    pix_addr  = a;
    pix_data  = d;
    cyc();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!idle && k < 200) begin
      cyc();
      k++;
    end
    check(name, idle, 1'b1);
  endtask

  task automatic do_flush(input string name);
    int k;
    flush = 1'b1;
    cyc();
    k = 0;
    while (!idle && k < 200) begin
      cyc();
      k++;
    end
    flush = 1'b0;
    check(name, idle, 1'b1);
  endtask

  task automatic check_log(input string name, input int idx, input logic [17:0] a,
                           input logic [15:0] d, input logic [3:0] m);
    if (idx >= lg_addr.size()) begin
      check({name, "_present"}, 32'd0, 32'd1);
    end else begin
      check({name, "_addr"}, lg_addr[idx], a);
      check({name, "_data"}, lg_data[idx], d);
      check({name, "_mask"}, lg_mask[idx], m);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    logic [17:0] cur_w;
    logic [17:0] pick;

    // Reset values.
    #3;
    check("rst_pix_ready", pix_ready, 1'b1);
    check("rst_idle", idle, 1'b1);
    check("rst_wr_req", wr_req, 1'b0);
    check("rst_wr_addr", wr_addr, 18'h0);
    check("rst_wr_data", wr_data, 16'h0);
    check("rst_wr_mask", wr_mask, 4'h0);
    cyc();
    reset_n = 1'b1;
    cyc();

    // Four pixels, one word.
    wr_ack = 1'b1;
    n0 = lg_addr.size();
    send(20'h00010, 4'h1);
    send(20'h00011, 4'h2);
    send(20'h00012, 4'h3);
    send(20'h00013, 4'h4);
    wait_idle("full_idle");
    check("full_count", lg_addr.size() - n0, 1);
    check_log("full", n0, 18'h00004, 16'h4321, 4'hF);

    // Word change, then flush of the second word.
    n0 = lg_addr.size();
    send(20'h00000, 4'h5);
    send(20'h00008, 4'h6);
    do_flush("chg_flush_idle");
    check("chg_count", lg_addr.size() - n0, 2);
    check_log("chg0", n0, 18'h0, 16'h0005, 4'h1);
    check_log("chg1", n0 + 1, 18'h2, 16'h0006, 4'h1);

    // Back-pressure: five cycles without ack, a pixel waiting meanwhile.
    wr_ack = 1'b0;
    n0 = lg_addr.size();
    send(20'h00020, 4'h7);
    send(20'h00021, 4'h8);
    send(20'h00022, 4'h9);
    send(20'h00023, 4'hA);
    pix_valid = 1'b1;
    pix_addr  = 20'h00024;
    pix_data  = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", pix_ready, 1'b0);
      check("bp_req", wr_req, 1'b1);
      check("bp_addr", wr_addr, 18'h00008);
      check("bp_data", wr_data, 16'hA987);
      check("bp_mask", wr_mask, 4'hF);
      cyc();
    end
    wr_ack = 1'b1;
    cyc();
    cyc();
    pix_valid = 1'b0;
    do_flush("bp_flush_idle");
    check("bp_count", lg_addr.size() - n0, 2);
    check_log("bp0", n0, 18'h00008, 16'hA987, 4'hF);
    check_log("bp1", n0 + 1, 18'h00009, 16'h0003, 4'h1);

    // Overwrite of one nibble, then flush.
    n0 = lg_addr.size();
    send(20'h00007, 4'hA);
    send(20'h00007, 4'hB);
    do_flush("ovw_idle");
    check("ovw_count", lg_addr.size() - n0, 1);
    check_log("ovw", n0, 18'h00001, 16'hB000, 4'h8);

    // Out of range (word MAX_WORD+1) leaves the buffer alone; MAX_WORD itself
    // is still written.
    n0 = lg_addr.size();
    send(20'h00040, 4'h5);
    send(20'hB71D4, 4'hF);
    do_flush("oor_idle");
    check("oor_count", lg_addr.size() - n0, 1);
    check_log("oor", n0, 18'h00010, 16'h0005, 4'h1);
    n0 = lg_addr.size();
    send(20'hB71D3, 4'h9);
    do_flush("maxw_idle");
    check_log("maxw", n0, 18'h2DC74, 16'h9000, 4'h8);

`ifdef OCM_SKIP_TRANSPARENT_EN
    // Four transparent pixels complete a word that has nothing to write.
    n0 = lg_addr.size();
    send(20'h00030, 4'h0);
    send(20'h00031, 4'h0);
    send(20'h00032, 4'h0);
    send(20'h00033, 4'h0);
    cyc();
    check("skip_count", lg_addr.size() - n0, 0);
    check("skip_idle", idle, 1'b1);
`endif

    // Reset while a write is pending.
    wr_ack = 1'b0;
    send(20'h00000, 4'h1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("rstmid_pre_req", wr_req, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_req", wr_req, 1'b0);
    check("rstmid_idle", idle, 1'b1);
    check("rstmid_ready", pix_ready, 1'b1);
    check("rstmid_addr", wr_addr, 18'h0);
    check("rstmid_data", wr_data, 16'h0);
    check("rstmid_mask", wr_mask, 4'h0);
    cyc();
    reset_n = 1'b1;
    wr_ack  = 1'b1;
    cyc();

    // Randomized traffic, mostly staying on one word so words fill up.
    cur_w = 18'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 6))
          0: pick = 18'h0;
          1: pick = 18'h1;
          2: pick = 18'h2;
          3: pick = 18'(MAX_WORD - 1);
          4: pick = 18'(MAX_WORD);
          5: pick = 18'(MAX_WORD + 1);
          default: pick = 18'h3FFFF;
        endcase
        cur_w = pick;
      end
      pix_valid = ($urandom_range(0, 99) < 70);
      pix_addr  = {cur_w, 2'($urandom_range(0, 3))};
      pix_data  = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 99) < 8);
      wr_ack    = ($urandom_range(0, 99) < 60);
      cyc();
    end
    pix_valid = 1'b0;
    wr_ack    = 1'b1;
    do_flush("drain_idle");
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ocm_pixel_writer.md
# ocm_pixel_writer

- Write-side counterpart of the 4-bit-pixel on-chip memory.
- Accepts a stream of 4-bit palette-index pixels addressed by a 20-bit pixel address.
- Packs pixels that fall in the same 16-bit word (pixel n of a word at bits 4n+3:4n) and issues one masked word write per packed word.
- Sits between the sprite/frame renderer and the 16-bit memory write port, so the graphics memory is filled with a quarter of the write transactions.

## Interface
Parameters:
- MAX_WORD, 187508: highest valid word address. Pixels whose word address exceeds it are accepted and discarded.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- pix_valid  in  1  pixel offered.
- pix_ready  out  1  writer can accept a pixel this cycle.
- pix_addr  in  20  pixel address. [19:2] is the word address; [1:0] is the nibble index.
- pix_data  in  4  pixel value.
- flush  in  1  request to emit the partially filled word.
- idle  out  1  accumulation buffer empty and no write outstanding.
- wr_req  out  1  word write request.
- wr_ack  in  1  memory accepted the write (may be high in the first wr_req cycle).
- wr_addr  out  18  word address of the write.
- wr_data  out  16  packed word.
- wr_mask  out  4  nibble enables; bit n enables wr_data[4n+3:4n].

## Operation
FSM states: IDLE (buffer empty), FILL (buffer holds 1–3 nibbles), WRITE (wr_req high).

- **Accept:** a pixel is accepted when pix_valid && pix_ready. pix_ready = 1 in IDLE and FILL, 0 in WRITE.
- **IDLE + accept:** buffer word address <= pix_addr[19:2]; the pixel is loaded into its nibble; mask bit set. Go to FILL.
- **FILL + accept, same word:** the pixel is merged into the buffer. Rewriting an already-set nibble overwrites it (last wins).
- **FILL + accept, different word:** the buffer moves to the output registers and wr_req is set. The buffer is reloaded with the new pixel only. Go to WRITE; on wr_ack return to FILL.
- **Full buffer:** a merge that makes the mask 4'b1111 emits immediately. Go to WRITE; on wr_ack return to IDLE.
- **Flush in FILL, no accept:** emit the buffer; WRITE, then IDLE.
- **Flush with a same-word accept:** merge the pixel, then emit.
- **Flush with a different-word accept:** the old word is emitted and the flush is ignored. The caller holds flush until idle = 1.
- **Flush in IDLE:** no effect.
- **Out-of-range pixel** (pix_addr[19:2] > MAX_WORD): accepted and has no effect on the buffer. It does not trigger a word-change emit.
- **Mask semantics:** an emitted wr_mask is never 0 (see Configuration for the exception path).

## Timing
- Reset values: pix_ready = 1, idle = 1, wr_req = 0, wr_addr = 0, wr_data = 0, wr_mask = 0. The buffer is cleared and the state is IDLE.
- wr_req rises the cycle after the triggering accept or flush.
- wr_addr, wr_data and wr_mask are stable while wr_req = 1.
- The write completes on the rising edge where wr_req && wr_ack. wr_req is low the following cycle.
- Minimum WRITE duration: 1 cycle, when wr_ack is already high.
- Sustained throughput for sequential full words: 4 accept cycles + 1 WRITE cycle per word.
- reset_n low mid-operation: the pending write is abandoned, the buffer is lost, and outputs return to reset values immediately.

## Configuration
Macro `OCM_SKIP_TRANSPARENT_EN`.

- **Defined:** pixels with pix_data = 4'h0 are accepted, but their mask bit is cleared and their nibble is left untouched.
  - A full-word emit still occurs when every index 0–3 has been seen.
  - A word whose resulting mask is 0 is dropped with no wr_req: the state goes directly to IDLE, or to FILL with the new pixel.
- **Undefined:** value 0 is written like any other value.

## Structure
- Package ocm_pkg: PIX_W = 4, WORD_W = 16, PIX_PER_WORD = 4, PADDR_W = 20, WADDR_W = 18, and the state enum (IDLE, FILL, WRITE).
- One sub-module, ocm_word_buffer, holds the accumulation register. It provides load/merge/clear, the nibble-merge logic, and the "full" and "empty mask" flags.
- The top level holds the FSM and the output registers.

## Test plan
- **Four pixels, one word:** addr 0x00010..0x00013, data 1,2,3,4 → one write, wr_addr = 0x00004, wr_data = 0x4321, wr_mask = 4'hF, idle = 1 afterwards.
- **Word change:** pixels at 0x00000 (data 5) then 0x00008 (data 6) → write wr_addr = 0, wr_data = 0x0005, wr_mask = 4'h1. Flush then writes wr_addr = 2, wr_data = 0x0006, mask 4'h1.
- **Back-pressure:** wr_ack held low 5 cycles → pix_ready = 0 and wr_* constant for those 5 cycles; no pixel is lost.
- **Overwrite and flush:** addr 0x7 data A, addr 0x7 data B, flush → wr_addr = 1, wr_data = 0xB000, mask 4'h8.
- **Out of range:** pixel at word 187509 → no write; the buffer is unchanged.
- **Reset with wr_req high:** assert reset_n = 0 → wr_req = 0 and idle = 1 asynchronously. With `OCM_SKIP_TRANSPARENT_EN`: four data-0 pixels → no write.
